// File: rtl/rom_responder.sv
// rtl/rom_responder.sv - boot-ROM bus responder: snoops line reads, queues them, drives 8-beat fills.
// Optional: define ROM_SNOOP_HIT_EN to skip enqueue when a cache reports a hit.
`ifndef CMD_READ
`define CMD_READ  3'd1
`endif
`ifndef CMD_RDX
`define CMD_RDX   3'd2
`endif
`ifndef CMD_WRITE
`define CMD_WRITE 3'd3
`endif
`ifndef CMD_FILL
`define CMD_FILL  3'd4
`endif

module rom_responder #(
    parameter logic [25:0] ROM_BASE       = 26'h3FFC000,
    parameter int          ROM_LINES_LOG2 = 10,
    parameter int          QDEPTH_LOG2    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_valid,
    input  logic                      bus_nack,
    input  logic                      bus_hit,
    input  logic [2:0]                bus_cmd,
    input  logic [4:0]                bus_tag,
    input  logic [25:0]               bus_addr,
    input  logic                      bus_rom_grant,
    output logic                      rom_bus_req,
    output logic [2:0]                rom_bus_cmd,
    output logic [4:0]                rom_bus_tag,
    output logic [25:0]               rom_bus_addr,
    output logic [63:0]               rom_bus_data,
    output logic                      rom_bus_nack,
    output logic                      rom_rd_en,
    output logic [ROM_LINES_LOG2+2:0] rom_rd_addr,
    input  logic [63:0]               rom_rd_data
);
    localparam int LW     = ROM_LINES_LOG2;
    localparam int QDEPTH = 1 << QDEPTH_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [2:0]             cyc_r;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt;
    logic [4:0]             q_tag  [QDEPTH];
    logic [LW-1:0]          q_line [QDEPTH];
    logic [QDEPTH_LOG2-1:0] rd_ptr_r;
    logic [QDEPTH_LOG2-1:0] wr_ptr_r;
    logic [QDEPTH_LOG2:0]   count_r;

    logic          last;
    logic          snoop_match;
    logic          q_full;
    logic          q_empty;
    logic          q_more;
    logic          hit_block;
    logic          enq;
    logic          pop;
    logic [4:0]    head_tag;
    logic [LW-1:0] head_line;
    logic [LW-1:0] next_line;

    assign last        = (cyc_r == 3'd7);
    assign snoop_match = bus_valid && (bus_cmd == `CMD_READ || bus_cmd == `CMD_RDX)
                         && (bus_addr[25:LW] == ROM_BASE[25:LW]);
    // count never exceeds QDEPTH, so its MSB alone flags full
    assign q_full      = count_r[QDEPTH_LOG2];
    assign q_empty     = (count_r == '0);
    assign q_more      = (count_r > (QDEPTH_LOG2+1)'(1));
    assign head_tag    = q_tag[rd_ptr_r];
    assign head_line   = q_line[rd_ptr_r];
    assign next_line   = q_line[rd_ptr_r + (QDEPTH_LOG2)'(1)];

`ifdef ROM_SNOOP_HIT_EN
    assign hit_block = bus_hit;
`else
    logic hit_unused;
    assign hit_unused = bus_hit;
    assign hit_block  = 1'b0;
`endif

    // nack is decided from our own queue state only, never from bus_nack/bus_hit
    assign rom_bus_nack = last && snoop_match && q_full;
    assign enq = last && snoop_match && !q_full && !bus_nack && !hit_block;
    assign pop = (state_r == ST_XFER) && last && !bus_nack;

    always_comb begin
        rom_bus_req  = 1'b0;
        rom_bus_cmd  = 3'd0;
        rom_bus_tag  = 5'd0;
        rom_bus_addr = 26'd0;
        rom_bus_data = 64'd0;
        rom_rd_en    = 1'b0;
        rom_rd_addr  = '0;
        state_nxt    = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!q_empty) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                rom_bus_req  = 1'b1;
                rom_bus_cmd  = `CMD_FILL;
                rom_bus_tag  = head_tag;
                rom_bus_addr = {ROM_BASE[25:LW], head_line};
                if (last && bus_rom_grant) begin
                    rom_rd_en   = 1'b1;
                    rom_rd_addr = {head_line, 3'd0};
                    state_nxt   = ST_XFER;
                end
            end
            ST_XFER: begin
                rom_bus_cmd  = `CMD_FILL;
                rom_bus_tag  = head_tag;
                rom_bus_addr = {ROM_BASE[25:LW], head_line};
                rom_bus_data = rom_rd_data;
                if (!last) begin
                    rom_rd_en   = 1'b1;
                    rom_rd_addr = {head_line, cyc_r + 3'd1};
                end else if (bus_nack) begin
                    state_nxt = ST_REQ;
                end else if (q_more) begin
                    // re-arbitrate now so the next fill can take the following slot
                    rom_bus_req = 1'b1;
                    if (bus_rom_grant) begin
                        rom_rd_en   = 1'b1;
                        rom_rd_addr = {next_line, 3'd0};
                        state_nxt   = ST_XFER;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r    <= 3'd0;
            state_r  <= ST_IDLE;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            cyc_r   <= cyc_r + 3'd1;
            state_r <= state_nxt;
            if (enq) wr_ptr_r <= wr_ptr_r + (QDEPTH_LOG2)'(1);
            if (pop) rd_ptr_r <= rd_ptr_r + (QDEPTH_LOG2)'(1);
            case ({enq, pop})
                2'b10:   count_r <= count_r + (QDEPTH_LOG2+1)'(1);
                2'b01:   count_r <= count_r - (QDEPTH_LOG2+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_tag[wr_ptr_r]  <= bus_tag;
            q_line[wr_ptr_r] <= bus_addr[LW-1:0];
        end
    end
endmodule
